// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, shadow-entry layout and hazard helper functions
// for the 5-stage MIPS stall/forward controller.
package hazard_ctrl_pkg;

    localparam int RW = 5;
    localparam int TW = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] FD_RF     = 2'd0;
    localparam logic [1:0] FD_EM_ALU = 2'd1;
    localparam logic [1:0] FD_EM_PC8 = 2'd2;
    localparam logic [1:0] FD_MW     = 2'd3;

    localparam logic [1:0] FE_REG    = 2'd0;
    localparam logic [1:0] FE_EM_ALU = 2'd1;
    localparam logic [1:0] FE_MW     = 2'd2;

    localparam logic [TW-1:0] TUSE_0 = 2'd0;
    localparam logic [TW-1:0] TUSE_1 = 2'd1;
    localparam logic [TW-1:0] TUSE_2 = 2'd2;
    localparam logic [TW-1:0] TNEW_0 = 2'd0;
    localparam logic [TW-1:0] TNEW_1 = 2'd1;
    localparam logic [TW-1:0] TNEW_2 = 2'd2;

    localparam logic [RW-1:0] REG_ZERO = 5'd0;
    localparam logic [RW-1:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef struct packed {
        logic          use_rs;
        logic          use_rt;
        logic [TW-1:0] tuse_rs;
        logic [TW-1:0] tuse_rt;
        logic [RW-1:0] wa;
        logic [TW-1:0] tnew;
        logic          is_md;
        logic          md_go;
        md_op_e        md_op;
        logic          is_jal;
        logic          is_lw;
    } dec_t;

    // rs/rt are stored only when the instruction actually reads them
    typedef struct packed {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wa;
        logic [TW-1:0] tnew;
        logic          is_lw;
        logic          is_jal;
        logic          md_go;
        md_op_e        md_op;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    function automatic logic src_stall(
        input logic [RW-1:0] src,
        input logic [TW-1:0] tuse,
        input shadow_t       e,
        input shadow_t       m
    );
        if (src == REG_ZERO) return 1'b0;
        if (e.wa == src) return e.tnew > tuse;
        if (m.wa == src) return m.tnew > tuse;
        return 1'b0;
    endfunction

    function automatic logic [1:0] fwd_d_sel(
        input logic [RW-1:0] src,
        input shadow_t       e,
        input shadow_t       m,
        input shadow_t       w
    );
        if (src == REG_ZERO) return FD_RF;
        if (e.wa == src) return FD_RF;
        if (m.wa == src) begin
            if (m.tnew != TNEW_0) return FD_RF;
            return m.is_jal ? FD_EM_PC8 : FD_EM_ALU;
        end
        if (w.wa == src) return FD_MW;
        return FD_RF;
    endfunction

    function automatic logic [1:0] fwd_e_sel(
        input logic [RW-1:0] src,
        input shadow_t       m,
        input shadow_t       w
    );
        if (src == REG_ZERO) return FE_REG;
        if (m.wa == src) return (m.tnew == TNEW_0) ? FE_EM_ALU : FE_REG;
        if (w.wa == src) return FE_MW;
        return FE_REG;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational op/funct decode into operand use times, write address,
// result-ready time and multiply/divide class.
module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [5:0]    op_i,
    input  logic [5:0]    funct_i,
    input  logic [RW-1:0] rt_i,
    input  logic [RW-1:0] rd_i,
    output dec_t          dec_o
);

    logic r;

    always_comb begin
        dec_o = '0;
        r = (op_i == OP_RTYPE);
        unique case (1'b1)
            r && (funct_i == FN_ADDU || funct_i == FN_SUBU ||
                  funct_i == FN_SLT): begin
                dec_o.use_rs  = 1'b1;
                dec_o.use_rt  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_1;
                dec_o.wa      = rd_i;
                dec_o.tnew    = TNEW_1;
            end
            r && (funct_i == FN_JR): begin
                dec_o.use_rs  = 1'b1;
                dec_o.tuse_rs = TUSE_0;
            end
            r && (funct_i == FN_MULT || funct_i == FN_MULTU ||
                  funct_i == FN_DIV  || funct_i == FN_DIVU): begin
                dec_o.use_rs  = 1'b1;
                dec_o.use_rt  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_1;
                dec_o.is_md   = 1'b1;
                dec_o.md_go   = 1'b1;
                dec_o.md_op   = md_op_e'(funct_i[1:0]);
            end
            r && (funct_i == FN_MFHI || funct_i == FN_MFLO): begin
                dec_o.wa    = rd_i;
                dec_o.tnew  = TNEW_1;
                dec_o.is_md = 1'b1;
            end
            r && (funct_i == FN_MTHI || funct_i == FN_MTLO): begin
                dec_o.use_rs  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.is_md   = 1'b1;
            end
            (op_i == OP_ORI || op_i == OP_ADDIU): begin
                dec_o.use_rs  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.wa      = rt_i;
                dec_o.tnew    = TNEW_1;
            end
            (op_i == OP_LUI): begin
                dec_o.wa   = rt_i;
                dec_o.tnew = TNEW_1;
            end
            (op_i == OP_LW): begin
                dec_o.use_rs  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.wa      = rt_i;
                dec_o.tnew    = TNEW_2;
                dec_o.is_lw   = 1'b1;
            end
            (op_i == OP_SW): begin
                dec_o.use_rs  = 1'b1;
                dec_o.use_rt  = 1'b1;
                dec_o.tuse_rs = TUSE_1;
                dec_o.tuse_rt = TUSE_2;
            end
            (op_i == OP_BEQ): begin
                dec_o.use_rs  = 1'b1;
                dec_o.use_rt  = 1'b1;
                dec_o.tuse_rs = TUSE_0;
                dec_o.tuse_rt = TUSE_0;
            end
            (op_i == OP_JAL): begin
                dec_o.wa     = REG_RA;
                dec_o.tnew   = TNEW_0;
                dec_o.is_jal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller: shadow E/M/W destination pipeline plus the
// multiply/divide busy sequencer.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [5:0]    d_op,
    input  logic [5:0]    d_funct,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_rd,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic          fwd_m_rt,
    output logic          md_start,
    output logic [1:0]    md_op,
    output logic          md_busy
);

    localparam int unsigned CMAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW = $clog2(CMAX + 1);

    dec_t          dec;
    shadow_t       e_q, m_q, w_q;
    shadow_t       e_d, m_d, w_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] src_rs, src_rt;
    logic          dep_stall, md_stall;
    logic          unused_w;

    hazard_decode u_dec (
        .op_i    (d_op),
        .funct_i (d_funct),
        .rt_i    (d_rt),
        .rd_i    (d_rd),
        .dec_o   (dec)
    );

    // Only WA of the W entry feeds any decision
    assign unused_w = ^w_q;

    always_comb begin
        src_rs = dec.use_rs ? d_rs : REG_ZERO;
        src_rt = dec.use_rt ? d_rt : REG_ZERO;

        md_start = e_q.md_go;
        md_busy  = (cnt_q != '0);
        md_op    = md_start ? e_q.md_op : 2'b00;

        dep_stall = src_stall(src_rs, dec.tuse_rs, e_q, m_q) |
                    src_stall(src_rt, dec.tuse_rt, e_q, m_q);
        md_stall  = dec.is_md & (md_busy | md_start);
        stall     = dep_stall | md_stall;

        fwd_d_rs = fwd_d_sel(src_rs, e_q, m_q, w_q);
        fwd_d_rt = fwd_d_sel(src_rt, e_q, m_q, w_q);
        fwd_e_rs = fwd_e_sel(e_q.rs, m_q, w_q);
        fwd_e_rt = fwd_e_sel(e_q.rt, m_q, w_q);
        fwd_m_rt = (m_q.rt != REG_ZERO) && (m_q.rt == w_q.wa);

        e_d = BUBBLE;
        if (!stall) begin
            e_d.rs     = src_rs;
            e_d.rt     = src_rt;
            e_d.wa     = dec.wa;
            e_d.tnew   = dec.tnew;
            e_d.is_lw  = dec.is_lw;
            e_d.is_jal = dec.is_jal;
            e_d.md_go  = dec.md_go;
            e_d.md_op  = dec.md_op;
        end

        m_d = e_q;
        m_d.tnew = (e_q.tnew == TNEW_0) ? TNEW_0 : e_q.tnew - TNEW_1;
        w_d = m_q;

        cnt_d = cnt_q;
        if (md_start) begin
            if (e_q.md_op == MD_DIV || e_q.md_op == MD_DIVU)
                cnt_d = CW'(DIV_CYC);
            else
                cnt_d = CW'(MULT_CYC);
        end else if (md_busy) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= BUBBLE;
            m_q   <= BUBBLE;
            w_q   <= BUBBLE;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int X = -1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] d_op = '0;
    logic [5:0] d_funct = '0;
    logic [4:0] d_rs = '0;
    logic [4:0] d_rt = '0;
    logic [4:0] d_rd = '0;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic       fwd_m_rt, md_start, md_busy;
    logic [1:0] md_op;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_op     (d_op),
        .d_funct  (d_funct),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_rd     (d_rd),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt),
        .fwd_m_rt (fwd_m_rt),
        .md_start (md_start),
        .md_op    (md_op),
        .md_busy  (md_busy)
    );

    typedef struct {
        string name;
        int    cyc;
        int    st, fdrs, fdrt, fers, fert, fmrt, mds, mdop, busy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rtype(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0005};
    endfunction

    function automatic bit m(input int e, input int a);
        return (e < 0) || (e == a);
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins,
        input string nm, input int st, input int fdrs, input int fdrt,
        input int fers, input int fert, input int fmrt,
        input int mds, input int mdop, input int busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        d_op    = ins[31:26];
        d_rs    = ins[25:21];
        d_rt    = ins[20:16];
        d_rd    = ins[15:11];
        d_funct = ins[5:0];
        e.name = nm; e.cyc = cyc;
        e.st = st; e.fdrs = fdrs; e.fdrt = fdrt;
        e.fers = fers; e.fert = fert; e.fmrt = fmrt;
        e.mds = mds; e.mdop = mdop; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [31:0] ins, input string nm);
        step(1'b1, ins, nm, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            ok = (e.cyc == cyc) && m(e.st, int'(stall)) &&
                 m(e.fdrs, int'(fwd_d_rs)) && m(e.fdrt, int'(fwd_d_rt)) &&
                 m(e.fers, int'(fwd_e_rs)) && m(e.fert, int'(fwd_e_rt)) &&
                 m(e.fmrt, int'(fwd_m_rt)) && m(e.mds, int'(md_start)) &&
                 m(e.mdop, int'(md_op)) && m(e.busy, int'(md_busy));
            n_run++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got st=%0d fd=%0d/%0d fe=%0d/%0d fm=%0d mds=%0d mdop=%0d busy=%0d exp st=%0d fd=%0d/%0d fe=%0d/%0d fm=%0d mds=%0d mdop=%0d busy=%0d",
                    e.name, e.cyc, stall, fwd_d_rs, fwd_d_rt, fwd_e_rs,
                    fwd_e_rt, fwd_m_rt, md_start, md_op, md_busy,
                    e.st, e.fdrs, e.fdrt, e.fers, e.fert, e.fmrt,
                    e.mds, e.mdop, e.busy);
            end
        end
    end

    initial begin
        logic [31:0] nop, lw1, addu213, ori1, beq10, jal, jr31;
        logic [31:0] addu712, sw7, addu012, addu300, mult45, mflo6;
        logic [31:0] div45, addu321, addi12;
        nop     = '0;
        lw1     = itype(OP_LW, 5'd0, 5'd1);
        addu213 = rtype(FN_ADDU, 5'd1, 5'd3, 5'd2);
        ori1    = itype(OP_ORI, 5'd0, 5'd1);
        beq10   = itype(OP_BEQ, 5'd1, 5'd0);
        jal     = {OP_JAL, 26'd4};
        jr31    = rtype(FN_JR, 5'd31, 5'd0, 5'd0);
        addu712 = rtype(FN_ADDU, 5'd1, 5'd2, 5'd7);
        sw7     = itype(OP_SW, 5'd0, 5'd7);
        addu012 = rtype(FN_ADDU, 5'd1, 5'd2, 5'd0);
        addu300 = rtype(FN_ADDU, 5'd0, 5'd0, 5'd3);
        mult45  = rtype(FN_MULT, 5'd4, 5'd5, 5'd0);
        mflo6   = rtype(FN_MFLO, 5'd0, 5'd0, 5'd6);
        div45   = rtype(FN_DIV, 5'd4, 5'd5, 5'd0);
        addu321 = rtype(FN_ADDU, 5'd2, 5'd1, 5'd3);
        addi12  = itype(6'h08, 5'd1, 5'd2);

        step(1'b0, lw1,    "rst_hold_lw",  0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, mult45, "rst_hold_md",  0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(nop, "post_rst");

        idle(lw1, "lw_issue");
        step(1'b1, addu213, "lw_use_stall",   1, 0, 0, 0, 0, 0, 0, X, 0);
        step(1'b1, addu213, "lw_use_release", 0, 0, 0, 0, 0, 0, 0, X, 0);
        step(1'b1, nop,     "lw_fwd_e_mw",    0, 0, 0, 2, 0, 0, 0, X, 0);
        idle(nop, "lw_drain");

        idle(ori1, "ori_issue");
        step(1'b1, beq10, "beq_stall",    1, 0, 0, 0, 0, 0, 0, X, 0);
        step(1'b1, beq10, "beq_fwd_em",   0, 1, 0, 0, 0, 0, 0, X, 0);
        step(1'b1, nop,   "beq_e_from_w", 0, 0, 0, 2, 0, 0, 0, X, 0);
        idle(nop, "beq_drain");

        idle(jal, "jal_issue");
        idle(nop, "jal_slot");
        step(1'b1, jr31, "jr_fwd_pc8",  0, 2, 0, 0, 0, 0, 0, X, 0);
        step(1'b1, nop,  "jr_e_from_w", 0, 0, 0, 2, 0, 0, 0, X, 0);
        idle(nop, "jr_drain");

        idle(addu712, "sw_prod_issue");
        idle(sw7, "sw_no_stall");
        step(1'b1, nop, "sw_fwd_e_alu", 0, 0, 0, 0, 1, 0, 0, X, 0);
        step(1'b1, nop, "sw_fwd_m_rt",  0, 0, 0, 0, 0, 1, 0, X, 0);
        idle(nop, "sw_drain");

        idle(addu012, "r0_write_issue");
        idle(addu300, "r0_no_stall");
        idle(nop, "r0_no_fwd");

        idle(mult45, "mult_issue");
        step(1'b1, mflo6, "mult_start", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1'b1, mflo6, "mflo_busy", 1, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b1, mflo6, "mflo_release", 0, 0, 0, 0, 0, 0, 0, X, 0);
        idle(nop, "mflo_drain");

        idle(div45, "div_issue");
        step(1'b1, nop, "div_start", 0, 0, 0, 0, 0, 0, 1, 2, 0);
        step(1'b1, nop, "div_busy10", 0, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b1, nop, "div_busy9",  0, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b1, lw1, "div_bg_lw",  0, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b1, addu213, "div_bg_stall", 1, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b1, addu213, "div_busy6",    0, 0, 0, 0, 0, 0, 0, X, 1);
        step(1'b0, mflo6, "rst_mid_div", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, addu321, "rst_shadow_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(nop, "post_rst_idle");

        idle(ori1, "unsup_prod");
        idle(addi12, "unsup_no_read");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
